io_out_change_logger: RTL

//  Downstream capture stage for the benchmark wrapper's 8-bit io_out bus.

---
 rtl/io_log_pkg.sv | 11 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/io_out_change_logger.sv | 74 +++++++
 3 files changed

// File: rtl/io_log_pkg.sv
// io_log_pkg: shared defaults and log-entry layout for the io_out change logger.
package io_log_pkg;
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_TS_W   = 8;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int DROP_W         = 8;
    localparam int ENTRY_W        = DEFAULT_DATA_W + DEFAULT_TS_W;
    // An entry is {data, ts}: timestamp in the low bits, sample above it.
    localparam int TS_LSB         = 0;
    localparam int DATA_LSB       = DEFAULT_TS_W;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-array FIFO with a separate occupancy counter.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o    = level_q == LW'(DEPTH);
    assign empty_o   = level_q == '0;
    assign do_push   = push_i & (~full_o | pop_i);
    assign do_pop    = pop_i & ~empty_o;
    assign level_o   = level_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/io_out_change_logger.sv
// io_out_change_logger: logs each change of the sampled bus with a timestamp
// into a small FIFO drained over a valid/ready port; counts dropped changes.
module io_out_change_logger
    import io_log_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int TS_W   = DEFAULT_TS_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       capture_en,
    input  logic [DATA_W-1:0]          sample,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count
);
    localparam int EW = DATA_W + TS_W;

    logic [TS_W-1:0]   ts_q;
    logic [DATA_W-1:0] prev_q;
    logic              primed_q, overflow_q;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              push, pop, full, empty, drop;
    logic [EW-1:0]     rd_entry;

    assign push = capture_en & (~primed_q | (sample != prev_q));
    assign pop  = out_valid & out_ready;
    // A change that finds the FIFO full is lost unless a pop frees a slot now.
    assign drop = push & full & ~pop;
    assign drop_d = drop_q + DROP_W'(drop_q != '1);

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i ({sample, ts_q}),
        .rd_data_o (rd_entry),
        .level_o   (level),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign out_valid  = ~empty;
    assign out_data   = rd_entry[EW-1:TS_W];
    assign out_ts     = rd_entry[TS_W-1:0];
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

    always_ff @(posedge clk) begin
        if (reset | clear) begin
            ts_q       <= '0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q     <= ts_q + 1'b1;
            prev_q   <= capture_en ? sample : prev_q;
            primed_q <= capture_en;
            if (drop) begin
                overflow_q <= 1'b1;
                drop_q     <= drop_d;
            end
        end
    end
endmodule
